// File: rtl/writeback_queue.sv
// ----------------------------------------------------------------------------
// writeback_queue
//   In-order writeback buffer sitting between the two execution pipelines and
//   a dual-write-port register file. Up to two results are accepted per cycle
//   (slot 1 older than slot 2) and up to two are retired per cycle, oldest
//   first. When the two retiring entries target the same register, only the
//   younger one is written. A pending-write mask is exported for hazard
//   detection.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-low reset
//   valid1/destIn1/dataIn1 : older incoming result
//   valid2/destIn2/dataIn2 : younger incoming result
//   inReady      : queue has room for two results this cycle
//   stall        : inhibit draining this cycle
//   regWrite1/destReg1/writeData1 : register-file write port 1 (older entry)
//   regWrite2/destReg2/writeData2 : register-file write port 2 (younger entry)
//   pendingMask  : bit r set while any queued entry targets register r
//   count        : number of occupied entries
// ----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid1,
    input  logic [ADDR_W-1:0]       destIn1,
    input  logic [DATA_W-1:0]       dataIn1,
    input  logic                    valid2,
    input  logic [ADDR_W-1:0]       destIn2,
    input  logic [DATA_W-1:0]       dataIn2,
    output logic                    inReady,
    input  logic                    stall,
    output logic                    regWrite1,
    output logic [ADDR_W-1:0]       destReg1,
    output logic [DATA_W-1:0]       writeData1,
    output logic                    regWrite2,
    output logic [ADDR_W-1:0]       destReg2,
    output logic [DATA_W-1:0]       writeData2,
    output logic [(2**ADDR_W)-1:0]  pendingMask,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]             vld_q,  vld_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [1:0]       n_drain;
    logic [1:0]       n_enq;
    logic             acc1;
    logic             acc2;
    logic             collision;

    assign head_nxt = head_q + PTR_W'(1);
    assign tail_nxt = tail_q + PTR_W'(1);

    // Room for a full pair is judged on the registered count only, so the
    // upstream handshake never depends on this cycle's stall/drain.
    assign inReady = (count_q <= CNT_W'(DEPTH - 2));

    assign acc1  = inReady & valid1;
    assign acc2  = inReady & valid2;
    assign n_enq = 2'(acc1) + 2'(acc2);

    always_comb begin
        n_drain = 2'd0;
        if (!stall) begin
            if (count_q >= CNT_W'(2)) n_drain = 2'd2;
            else                      n_drain = count_q[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Write ports: always show the two head slots; only the enables gate.
    // ------------------------------------------------------------------
    assign destReg1   = dest_q[head_q];
    assign writeData1 = data_q[head_q];
    assign destReg2   = dest_q[head_nxt];
    assign writeData2 = data_q[head_nxt];

    // Same-register pair: drop the older write so the younger data lands.
    // Both entries still retire.
    assign collision = (n_drain == 2'd2) && (dest_q[head_q] == dest_q[head_nxt]);
    assign regWrite1 = (n_drain != 2'd0) && !collision;
    assign regWrite2 = (n_drain == 2'd2);

    assign count = count_q;

    // ------------------------------------------------------------------
    // Pending-write mask: includes entries retiring this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pendingMask[dest_q[i]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        dest_d  = dest_q;
        data_d  = data_q;
        vld_d   = vld_q;
        head_d  = head_q + PTR_W'(n_drain);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_drain);

        // Retire first. Enqueue only happens with at least two free slots,
        // so tail/tail+1 never alias an occupied (possibly retiring) slot.
        if (n_drain != 2'd0) vld_d[head_q]   = 1'b0;
        if (n_drain == 2'd2) vld_d[head_nxt] = 1'b0;

        if (acc1 && acc2) begin
            dest_d[tail_q]   = destIn1;
            data_d[tail_q]   = dataIn1;
            vld_d[tail_q]    = 1'b1;
            dest_d[tail_nxt] = destIn2;
            data_d[tail_nxt] = dataIn2;
            vld_d[tail_nxt]  = 1'b1;
        end else if (acc1) begin
            dest_d[tail_q]   = destIn1;
            data_d[tail_q]   = dataIn1;
            vld_d[tail_q]    = 1'b1;
        end else if (acc2) begin
            dest_d[tail_q]   = destIn2;
            data_d[tail_q]   = dataIn2;
            vld_d[tail_q]    = 1'b1;
        end
    end

    // Entry contents are cleared on reset so idle ports read zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dest_q  <= '0;
            data_q  <= '0;
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            dest_q  <= dest_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
